// File: rtl/rr_arb_bin.sv
// rr_arb_bin: round-robin arbiter that reports the winning requester as a
// binary index through a single registered valid/ready output slot.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req          [N-1:0] level-sensitive request vector
//   grant_valid  slot holds a grant
//   grant_ready  downstream accepts the grant this cycle
//   grant_idx    [IDX_W-1:0] binary index of the granted requester
//   grant_count  [15:0] saturating accepted-grant counter
//                (present only when RR_ARB_CNT_EN is defined)
//
// Optional feature macro: RR_ARB_CNT_EN
module rr_arb_bin #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic             grant_valid,
  input  logic             grant_ready,
  output logic [IDX_W-1:0] grant_idx
`ifdef RR_ARB_CNT_EN
  ,
  output logic [15:0]      grant_count
`endif
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_ptr;

  logic             w_accept;
  logic             w_arb_en;
  logic [N-1:0]     w_mask;
  logic [N-1:0]     w_eff;
  logic             w_found;
  logic [IDX_W-1:0] w_win;

  assign grant_valid = (r_state == S_FULL);
  assign grant_idx   = r_idx;

  always_comb begin
    w_accept = (r_state == S_FULL) && grant_ready;
    w_arb_en = (r_state == S_EMPTY) || w_accept;
    w_mask   = '0;
    if (w_accept) begin
      w_mask[r_idx] = 1'b1;
    end
    w_eff = req & ~w_mask;
  end

  // Rotating priority search starting just after ptr. N is a power of two,
  // so the IDX_W-bit sum wraps from N-1 back to 0 without an explicit modulo.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!w_found && w_eff[r_ptr + IDX_W'(k + 1)]) begin
        w_found = 1'b1;
        w_win   = r_ptr + IDX_W'(k + 1);
      end
    end
  end

  // Pointer moves only on acceptance; the search in an accepting cycle still
  // uses the old pointer, with the mask preventing a duplicate grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_idx   <= '0;
      r_ptr   <= '1;
    end else begin
      if (w_accept) begin
        r_ptr <= r_idx;
      end
      if (w_arb_en) begin
        if (w_found) begin
          r_state <= S_FULL;
          r_idx   <= w_win;
        end else begin
          r_state <= S_EMPTY;
        end
      end
    end
  end

`ifdef RR_ARB_CNT_EN
  logic [15:0] r_cnt;

  assign grant_count = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_arb_bin.sv
// Directed self-checking bench for rr_arb_bin (N=8). Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_rr_arb_bin;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       grant_valid;
  logic       grant_ready;
  logic [2:0] grant_idx;
`ifdef RR_ARB_CNT_EN
  logic [15:0] grant_count;
`endif

  int unsigned n_tests;
  int unsigned n_fail;

  rr_arb_bin #(.N(8), .IDX_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant_valid (grant_valid),
    .grant_ready (grant_ready),
    .grant_idx   (grant_idx)
`ifdef RR_ARB_CNT_EN
    ,
    .grant_count (grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n       = 1'b0;
    req         = '0;
    grant_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    req         = '0;
    grant_ready = 1'b0;
    #1;
    n_tests++;
    if (grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b want 0", grant_valid);
    end
    n_tests++;
    if (grant_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_idx: got %0d want 0", grant_idx);
    end
    do_reset();
  endtask

  task automatic test_rotation();
    logic [2:0] exp_idx [4] = '{3'd0, 3'd2, 3'd0, 3'd2};
    do_reset();
    req         = 8'b0000_0101;
    grant_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (grant_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rot_valid[%0d]: got %b want 1", i, grant_valid);
      end
      n_tests++;
      if (grant_idx !== exp_idx[i]) begin
        n_fail++;
        $display("FAIL rot_idx[%0d]: got %0d want %0d", i, grant_idx, exp_idx[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req         = 8'h80;
    grant_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (grant_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_valid[%0d]: got %b want 1", i, grant_valid);
      end
      n_tests++;
      if (grant_idx !== 3'd7) begin
        n_fail++;
        $display("FAIL bp_idx[%0d]: got %0d want 7", i, grant_idx);
      end
      if (i == 1) req = 8'h01;
    end
    grant_ready = 1'b1;
    @(negedge clk);
    grant_ready = 1'b0;
    n_tests++;
    if (grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_valid: got %b want 1", grant_valid);
    end
    n_tests++;
    if (grant_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL bp_release_idx: got %0d want 0", grant_idx);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req         = 8'h40;
    grant_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd6) begin
      n_fail++;
      $display("FAIL wrap_first: got valid=%b idx=%0d want valid=1 idx=6",
               grant_valid, grant_idx);
    end
    req = 8'b0100_0001;
    @(negedge clk);
    n_tests++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL wrap_next: got valid=%b idx=%0d want valid=1 idx=0",
               grant_valid, grant_idx);
    end
  endtask

  task automatic test_no_dup();
    logic exp_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    req         = 8'h10;
    grant_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (grant_valid !== exp_v[i]) begin
        n_fail++;
        $display("FAIL nodup_valid[%0d]: got %b want %b", i, grant_valid, exp_v[i]);
      end
      n_tests++;
      if (grant_idx !== 3'd4) begin
        n_fail++;
        $display("FAIL nodup_idx[%0d]: got %0d want 4", i, grant_idx);
      end
    end
  endtask

  task automatic test_idle();
    do_reset();
    req         = '0;
    grant_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if (grant_valid !== 1'b0 || grant_idx !== 3'd0) begin
        n_fail++;
        $display("FAIL idle[%0d]: got valid=%b idx=%0d want valid=0 idx=0",
                 i, grant_valid, grant_idx);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req         = 8'h20;
    grant_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd5) begin
      n_fail++;
      $display("FAIL arst_setup: got valid=%b idx=%0d want valid=1 idx=5",
               grant_valid, grant_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_valid: got %b want 0", grant_valid);
    end
    n_tests++;
    if (grant_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL arst_idx: got %0d want 0", grant_idx);
    end
    req         = 8'hFF;
    grant_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL arst_first: got valid=%b idx=%0d want valid=1 idx=0",
               grant_valid, grant_idx);
    end
    @(negedge clk);
    n_tests++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd1) begin
      n_fail++;
      $display("FAIL arst_second: got valid=%b idx=%0d want valid=1 idx=1",
               grant_valid, grant_idx);
    end
  endtask

`ifdef RR_ARB_CNT_EN
  task automatic test_counter();
    do_reset();
    n_tests++;
    if (grant_count !== 16'd0) begin
      n_fail++;
      $display("FAIL cnt_reset: got %0d want 0", grant_count);
    end
    req         = 8'b0000_0101;
    grant_ready = 1'b1;
    // First edge offers, the next three accept.
    repeat (4) @(negedge clk);
    grant_ready = 1'b0;
    n_tests++;
    if (grant_count !== 16'd3) begin
      n_fail++;
      $display("FAIL cnt_three: got %0d want 3", grant_count);
    end
    @(negedge clk);
    n_tests++;
    if (grant_count !== 16'd3) begin
      n_fail++;
      $display("FAIL cnt_hold: got %0d want 3", grant_count);
    end
    grant_ready = 1'b1;
    repeat (70000) @(negedge clk);
    n_tests++;
    if (grant_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL cnt_sat: got %h want ffff", grant_count);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (grant_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL cnt_sat_hold: got %h want ffff", grant_count);
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n       = 1'b1;
    req         = '0;
    grant_ready = 1'b0;
    test_reset();
    test_rotation();
    test_backpressure();
    test_wrap();
    test_no_dup();
    test_idle();
    test_async_reset();
`ifdef RR_ARB_CNT_EN
    test_counter();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
